uart_rx_stream: RTL and testbench

Receive-direction counterpart to the UART emitter. Samples an asynchronous 8N1 serial line and delivers each valid byte as an AXI-Stream-style beat (`tdata`/`tlast`/`tvalid`/`tready`). Beats are buffered in a small FIFO. The block sits between the board UART RX pin and any stream consumer in the core clock domain, for example a command parser feeding `corescorecore`.

---
 rtl/corescore_uart_pkg.sv | 8 +
 rtl/stream_fifo.sv | 40 ++++
 rtl/uart_rx_stream.sv | 100 ++++++++++
 tb/tb_uart_rx_stream.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/corescore_uart_pkg.sv
// corescore_uart_pkg: shared UART types, constants and baud helper
package corescore_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;
  localparam logic [7:0] LF = 8'h0A;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: show-ahead FIFO; a push into a full FIFO succeeds only alongside a pop
module stream_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             resetb,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_do_push, w_do_pop;
  assign o_empty = r_count == '0;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_rdata = r_mem[r_rd];
  assign w_do_pop = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  always_ff @(posedge i_clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_wdata;
        r_wr <= r_wr + 1'b1;
      end
      if (w_do_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end
endmodule

// File: rtl/uart_rx_stream.sv
// uart_rx_stream: 8N1 UART receiver delivering bytes as buffered stream beats
module uart_rx_stream
  import corescore_uart_pkg::*;
#(
  parameter int CLK_FREQ = 32000000,
  parameter int BAUD = 57600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       resetb,
  input  logic       i_uart_rx,
  output logic [7:0] o_tdata,
  output logic       o_tlast,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_frame_err,
  output logic       o_overrun
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BW = $clog2(CPB);
  localparam logic [BW-1:0] K_HALF = BW'(CPB / 2 - 1);
  localparam logic [BW-1:0] K_FULL = BW'(CPB - 1);
  logic r_s1, r_rx_s;
  rx_state_t r_state, w_next;
  logic [BW-1:0] r_baud, w_baud;
  logic [2:0] r_bit, w_bit;
  logic [7:0] r_shift, w_shift;
  logic w_push, w_ferr, w_full, w_empty, w_pop;
  logic [8:0] w_rdata;
  logic r_frame_err, r_overrun;
  always_comb begin
    w_next = r_state;
    w_baud = r_baud + 1'b1;
    w_bit = r_bit;
    w_shift = r_shift;
    w_push = 1'b0;
    w_ferr = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_baud = '0;
        if (!r_rx_s) w_next = START;
      end
      START: if (r_baud == K_HALF) begin
        w_baud = '0;
        w_bit = '0;
        w_next = r_rx_s ? IDLE : DATA;
      end
      DATA: if (r_baud == K_FULL) begin
        w_baud = '0;
        w_shift = {r_rx_s, r_shift[7:1]};
        w_bit = r_bit + 3'd1;
        if (r_bit == 3'd7) w_next = STOP;
      end
      STOP: if (r_baud == K_FULL) begin
        w_push = r_rx_s;
        w_ferr = !r_rx_s;
        w_next = r_rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: if (r_rx_s) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge resetb) begin
    if (!resetb) begin
      r_s1 <= 1'b1;
      r_rx_s <= 1'b1;
      r_state <= IDLE;
      r_baud <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_frame_err <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_s1 <= i_uart_rx;
      r_rx_s <= r_s1;
      r_state <= w_next;
      r_baud <= w_baud;
      r_bit <= w_bit;
      r_shift <= w_shift;
      r_frame_err <= w_ferr;
      r_overrun <= w_push && w_full && !w_pop;
    end
  end
  assign w_pop = !w_empty && i_tready;
  stream_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk(i_clk),
    .resetb(resetb),
    .i_push(w_push),
    .i_wdata({r_shift == LF, r_shift}),
    .o_full(w_full),
    .i_pop(w_pop),
    .o_rdata(w_rdata),
    .o_empty(w_empty)
  );
  assign o_tvalid = !w_empty;
  assign o_tdata = w_empty ? 8'h00 : w_rdata[7:0];
  assign o_tlast = !w_empty && w_rdata[8];
  assign o_frame_err = r_frame_err;
  assign o_overrun = r_overrun;
endmodule

// File: tb/tb_uart_rx_stream.sv
// tb_uart_rx_stream: directed scenarios for the stream UART receiver at 16 clocks per bit
module tb_uart_rx_stream;
  import corescore_uart_pkg::*;
  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic rx = 1'b1;
  logic tready = 1'b1;
  logic [7:0] tdata;
  logic tlast, tvalid, ferr, ovr;
  int n_pass = 0, n_total = 0;
  int cyc = 0, t0 = 0, rise_cyc = -1;
  int ferr_cnt = 0, ovr_cnt = 0, ovr_rise = 0;
  logic prev_v = 1'b0, prev_o = 1'b0;
  logic [8:0] beats[$];
  logic [8:0] got;
  uart_rx_stream #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(4)) dut (
    .i_clk(clk),
    .resetb(resetb),
    .i_uart_rx(rx),
    .o_tdata(tdata),
    .o_tlast(tlast),
    .o_tvalid(tvalid),
    .i_tready(tready),
    .o_frame_err(ferr),
    .o_overrun(ovr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (tvalid && !prev_v) rise_cyc = cyc;
    prev_v = tvalid;
    if (tvalid && tready) beats.push_back({tlast, tdata});
    if (ferr) ferr_cnt++;
    if (ovr) ovr_cnt++;
    if (ovr && !prev_o) ovr_rise++;
    prev_o = ovr;
  end
  task automatic clear();
    beats.delete();
    ferr_cnt = 0;
    ovr_cnt = 0;
    ovr_rise = 0;
    rise_cyc = -1;
  endtask
  task automatic send_bit(input logic b);
    @(posedge clk);
    #1 rx = b;
    repeat (15) @(posedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge clk);
    #1 rx = 1'b0;
    t0 = cyc;
    repeat (15) @(posedge clk);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask
  task automatic check_outputs_zero(input string tag);
    n_total++;
    if ({tvalid, tlast, ferr, ovr, tdata} !== 12'h000)
      $display("FAIL %s outputs: got tvalid=%b tlast=%b ferr=%b ovr=%b tdata=%h, want all 0", tag, tvalid, tlast, ferr, ovr, tdata);
    else n_pass++;
  endtask
  task automatic check_one_beat(input string tag, input logic [8:0] exp);
    got = beats.size() > 0 ? beats[0] : 9'h1FF;
    n_total++;
    if (beats.size() != 1) $display("FAIL %s beat count: got %0d, want 1", tag, beats.size());
    else n_pass++;
    n_total++;
    if (got !== exp) $display("FAIL %s beat: got {tlast,tdata}=%h, want %h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic test_reset();
    resetb = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    n_total++;
    if (dut.r_state !== IDLE) $display("FAIL reset state: got %0d, want IDLE", dut.r_state);
    else n_pass++;
    @(posedge clk);
    #1 resetb = 1'b1;
    repeat (5) @(posedge clk);
  endtask
  task automatic test_frame_55();
    clear();
    send_frame(8'h55, 1'b1);
    repeat (5) @(posedge clk);
    check_one_beat("frame55", 9'h055);
    n_total++;
    if (rise_cyc - t0 != 155) $display("FAIL frame55 latency: got %0d cycles, want 155", rise_cyc - t0);
    else n_pass++;
    n_total++;
    if (ferr_cnt != 0 || ovr_cnt != 0) $display("FAIL frame55 flags: got ferr=%0d ovr=%0d, want 0 0", ferr_cnt, ovr_cnt);
    else n_pass++;
  endtask
  task automatic test_lf();
    clear();
    send_frame(8'h0A, 1'b1);
    repeat (5) @(posedge clk);
    check_one_beat("lf", 9'h10A);
  endtask
  task automatic test_glitch();
    clear();
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (6) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    n_total++;
    if (beats.size() != 0 || ferr_cnt != 0 || ovr_cnt != 0)
      $display("FAIL glitch: got beats=%0d ferr=%0d ovr=%0d, want 0 0 0", beats.size(), ferr_cnt, ovr_cnt);
    else n_pass++;
    n_total++;
    if (dut.r_state !== IDLE) $display("FAIL glitch state: got %0d, want IDLE", dut.r_state);
    else n_pass++;
    send_frame(8'hA3, 1'b1);
    repeat (5) @(posedge clk);
    check_one_beat("after_glitch", 9'h0A3);
  endtask
  task automatic test_frame_err();
    clear();
    send_frame(8'h3C, 1'b0);
    repeat (40) @(posedge clk);
    #1 rx = 1'b1;
    repeat (20) @(posedge clk);
    n_total++;
    if (ferr_cnt != 1) $display("FAIL frame_err pulses: got %0d, want 1", ferr_cnt);
    else n_pass++;
    n_total++;
    if (beats.size() != 0) $display("FAIL frame_err beats: got %0d, want 0", beats.size());
    else n_pass++;
    send_frame(8'h11, 1'b1);
    repeat (5) @(posedge clk);
    check_one_beat("after_ferr", 9'h011);
    n_total++;
    if (ferr_cnt != 1) $display("FAIL after_ferr flags: got ferr=%0d, want 1", ferr_cnt);
    else n_pass++;
  endtask
  task automatic test_back_to_back();
    logic [8:0] exp [4] = '{9'h001, 9'h002, 9'h003, 9'h004};
    clear();
    @(posedge clk);
    #1 tready = 1'b0;
    for (int i = 1; i <= 6; i++) send_frame(8'(i), 1'b1);
    repeat (20) @(posedge clk);
    n_total++;
    if (ovr_cnt != 2 || ovr_rise != 2)
      $display("FAIL overrun pulses: got %0d high cycles in %0d pulses, want 2 in 2", ovr_cnt, ovr_rise);
    else n_pass++;
    n_total++;
    if (tvalid !== 1'b1 || tdata !== 8'h01) $display("FAIL stall head: got tvalid=%b tdata=%h, want 1 01", tvalid, tdata);
    else n_pass++;
    @(posedge clk);
    #1 tready = 1'b1;
    repeat (10) @(posedge clk);
    n_total++;
    if (beats.size() != 4) $display("FAIL drain count: got %0d, want 4", beats.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      got = beats.size() > i ? beats[i] : 9'h1FF;
      n_total++;
      if (got !== exp[i]) $display("FAIL drain beat %0d: got %h, want %h", i, got, exp[i]);
      else n_pass++;
    end
    #1;
    n_total++;
    if (tvalid !== 1'b0) $display("FAIL drain empty: got tvalid=%b, want 0", tvalid);
    else n_pass++;
  endtask
  task automatic test_reset_mid_frame();
    clear();
    @(posedge clk);
    #1 tready = 1'b0;
    send_frame(8'h5A, 1'b1);
    repeat (5) @(posedge clk);
    n_total++;
    if (tvalid !== 1'b1 || tdata !== 8'h5A) $display("FAIL pre_reset head: got tvalid=%b tdata=%h, want 1 5a", tvalid, tdata);
    else n_pass++;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (15) @(posedge clk);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (7) @(posedge clk);
    #3 resetb = 1'b0;
    #1 check_outputs_zero("mid_reset");
    n_total++;
    if (dut.r_state !== IDLE) $display("FAIL mid_reset state: got %0d, want IDLE", dut.r_state);
    else n_pass++;
    @(posedge clk);
    #1 resetb = 1'b1;
    tready = 1'b1;
    repeat (40) @(posedge clk);
    n_total++;
    if (beats.size() != 0) $display("FAIL mid_reset beats: got %0d, want 0", beats.size());
    else n_pass++;
    send_frame(8'h7E, 1'b1);
    repeat (5) @(posedge clk);
    check_one_beat("after_reset", 9'h07E);
  endtask
  initial begin
    test_reset();
    test_frame_55();
    test_lf();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
